ahb_cmd_arbiter: RTL and testbench
==================================

# ahb_cmd_arbiter

Round-robin arbiter and burst sequencer that shares the single AHB-Lite master's user-command port (enable, addr, w_data, htrans, hsize, hwrite, hburst, hselx) between NUM_REQ requesters. It sits in front of the master, on the user side, and drives its command inputs directly. It generates per-beat HTRANS (NONSEQ/SEQ/IDLE) and burst addresses (incrementing and wrapping), and holds the grant for a whole burst. It returns per-beat acknowledge, completion and error pulses to the granted requester.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 32: write-data width (32 or 64).
- HCLK  in  1  clock, rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held until done/err.
- req_addr  in  NUM_REQ*32  start address, requester i at [32*i+31:32*i].
- req_wdata  in  NUM_REQ*DATA_WIDTH  current-beat write data.
- req_hsize  in  NUM_REQ*3  transfer size.
- req_hburst  in  NUM_REQ*3  burst type (AHB encoding).
- req_hwrite  in  NUM_REQ  1 = write.
- req_hselx  in  NUM_REQ*2  slave select.
- hready  in  1  master ready; a beat is accepted when hready=1 in BUSY.
- hresp  in  1  error response, qualified by hready.
- enable, addr[31:0], w_data[DATA_WIDTH-1:0], htrans[1:0], hsize[2:0], hwrite, hburst[2:0], hselx[1:0]  out  command to master.
- gnt  out  NUM_REQ  one-hot grant, registered.
- beat_ack  out  NUM_REQ  gnt & accepted beat (combinational); requester advances req_wdata after it.
- done  out  NUM_REQ  one-cycle pulse after the final beat is accepted.
- err  out  NUM_REQ  one-cycle pulse on rejected request or hresp abort.

## Operation
- States: IDLE, BUSY.
- IDLE: scan req starting at (last+1) mod NUM_REQ; the first set bit wins. On the next edge, for winner g:
  - latch its addr, hsize, hburst, hwrite and hselx;
  - set gnt=1<<g, enable=1, htrans=NONSEQ (2);
  - set last=g and go to BUSY.
- Reject check: req_hsize[g] > log2(DATA_WIDTH/8) means no grant. Pulse err[g] for one cycle, update last=g, stay IDLE.
- Beat count from hburst:
  - SINGLE (0): 1 beat.
  - WRAP4/INCR4 (2/3): 4 beats.
  - WRAP8/INCR8 (4/5): 8 beats.
  - WRAP16/INCR16 (6/7): 16 beats.
  - INCR (1): undefined length; the burst continues while req[g]=1.
- Accepted beat, not last: addr += inc, where inc = 1<<hsize, with 32-bit wrap-around. htrans=SEQ (3). Remaining count decrements.
- WRAP bursts: mask = beats*inc-1; next addr = (addr & ~mask) | ((addr+inc) & mask).
- INCR/INCRx crossing a 1 KB boundary (next addr[31:10] differs): that beat is NONSEQ, not SEQ.
- INCR termination: the beat accepted with req[g]=0 sampled is the last beat.
- Accepted last beat: done[g]=1 for the next cycle. Go to IDLE with enable=0, htrans=IDLE (0), gnt=0.
- hresp=1 & hready=1 in BUSY: abort. Pulse err[g] for one cycle, suppress done, go to IDLE.
- hready=0 in BUSY: every command output and internal count holds.
- w_data = req_wdata slice g, combinational while BUSY; 0 otherwise.
- A requester dropping req mid fixed-length burst is ignored; the burst completes.

## Timing
- Reset values: enable=0, addr=0, htrans=0, hsize=0, hwrite=0, hburst=0, hselx=0, gnt=0, done=0, err=0, w_data=0, last=NUM_REQ-1 (so requester 0 has first priority), state IDLE.
- Arbitration latency: req seen in IDLE at edge N gives gnt/NONSEQ valid after edge N.
- Each accepted beat updates addr/htrans at the following edge.
- There is always at least one IDLE cycle between bursts, so re-arbitration takes one cycle.
- Async HRESET mid-burst: outputs return to reset values immediately; no done/err pulse.

## Test plan
- Single requester, req 1, addr 0x100, INCR4, hsize=2, hready=1 -> NONSEQ 0x100, then SEQ 0x104/0x108/0x10C. beat_ack[1] is high for 4 cycles, then done[1] pulses, then htrans=IDLE.
- WRAP4 at 0x38, hsize=2 -> addresses 0x38, 0x3C, 0x30, 0x34. WRAP8 hsize=1 at 0x0E -> 0x0E, 0x00, 0x02, …, 0x0C.
- All four req held, SINGLE each -> grants in order 0, 1, 2, 3, 0 with one IDLE cycle between bursts. gnt is never multi-hot.
- INCR at 0x3F8, hsize=2, req held for 4 beats -> 0x3F8 SEQ… 0x400 is issued as NONSEQ. Dropping req ends the burst after the current beat.
- hready=0 for 3 cycles mid INCR8 -> all outputs stable during the stall. Then hresp=1 on beat 5 -> err pulse, no done, IDLE.
- hsize=3 with DATA_WIDTH=32 -> err pulse, gnt stays 0. HRESET asserted mid-burst -> enable=0, htrans=0 immediately; after reset, requester 0 wins.

Source files
------------

// File: rtl/ahb_cmd_arbiter.sv
// Round-robin arbiter and burst sequencer feeding the AHB-Lite master's user-command port.
// Holds the grant for a whole burst and generates per-beat HTRANS and INCR/WRAP addresses.
module ahb_cmd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*32-1:0]         req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*3-1:0]          req_hsize,
  input  logic [NUM_REQ*3-1:0]          req_hburst,
  input  logic [NUM_REQ-1:0]            req_hwrite,
  input  logic [NUM_REQ*2-1:0]          req_hselx,
  input  logic                          hready,
  input  logic                          hresp,
  output logic                          enable,
  output logic [31:0]                   addr,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [1:0]                    htrans,
  output logic [2:0]                    hsize,
  output logic                          hwrite,
  output logic [2:0]                    hburst,
  output logic [1:0]                    hselx,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            beat_ack,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err
);

  localparam int         IDXW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] MAX_SIZE  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] HB_INCR   = 3'd1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                state_q, state_d;
  logic [IDXW-1:0]       last_q, last_d;
  logic [IDXW-1:0]       gidx_q, gidx_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  enable_q, enable_d;
  logic [31:0]           addr_q, addr_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [2:0]            hsize_q, hsize_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hburst_q, hburst_d;
  logic [1:0]            hselx_q, hselx_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    err_q, err_d;

  function automatic logic [4:0] burst_len(input logic [2:0] hb);
    case (hb)
      3'd2, 3'd3: burst_len = 5'd4;
      3'd4, 3'd5: burst_len = 5'd8;
      3'd6, 3'd7: burst_len = 5'd16;
      default:    burst_len = 5'd1;
    endcase
  endfunction

  // Round-robin scan: the requester after the last one granted (or rejected) has priority.
  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IDXW'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  logic [31:0] win_addr;
  logic [2:0]  win_hsize;
  logic [2:0]  win_hburst;
  logic [1:0]  win_hselx;

  assign win_addr   = req_addr[32*win_idx +: 32];
  assign win_hsize  = req_hsize[3*win_idx +: 3];
  assign win_hburst = req_hburst[3*win_idx +: 3];
  assign win_hselx  = req_hselx[2*win_idx +: 2];

  logic [31:0] inc;
  logic [31:0] sum;
  logic [31:0] wrap_mask;
  logic [31:0] next_addr;
  logic        is_wrap;
  logic        cross_1k;
  logic        last_beat;

  assign inc       = 32'd1 << hsize_q;
  assign sum       = addr_q + inc;
  assign is_wrap   = (hburst_q != 3'd0) && !hburst_q[0];
  assign wrap_mask = (32'(burst_len(hburst_q)) << hsize_q) - 32'd1;
  assign next_addr = is_wrap ? ((addr_q & ~wrap_mask) | (sum & wrap_mask)) : sum;
  // Wrapping bursts stay inside their aligned block, so only incrementing ones can cross 1 KB.
  assign cross_1k  = !is_wrap && (next_addr[31:10] != addr_q[31:10]);
  assign last_beat = (hburst_q == HB_INCR) ? !req[gidx_q] : (cnt_q == 5'd1);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gidx_d   = gidx_q;
    gnt_d    = gnt_q;
    enable_d = enable_q;
    addr_d   = addr_q;
    htrans_d = htrans_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    hburst_d = hburst_q;
    hselx_d  = hselx_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    err_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          last_d = win_idx;
          if (win_hsize > MAX_SIZE) begin
            err_d[win_idx] = 1'b1;
          end else begin
            state_d  = S_BUSY;
            gidx_d   = win_idx;
            gnt_d    = NUM_REQ'(1) << win_idx;
            enable_d = 1'b1;
            htrans_d = TR_NONSEQ;
            addr_d   = win_addr;
            hsize_d  = win_hsize;
            hburst_d = win_hburst;
            hwrite_d = req_hwrite[win_idx];
            hselx_d  = win_hselx;
            cnt_d    = burst_len(win_hburst);
          end
        end
      end

      S_BUSY: begin
        if (hready) begin
          if (hresp || last_beat) begin
            state_d  = S_IDLE;
            gnt_d    = '0;
            enable_d = 1'b0;
            htrans_d = TR_IDLE;
            if (hresp) begin
              err_d = gnt_q;
            end else begin
              done_d = gnt_q;
            end
          end else begin
            addr_d   = next_addr;
            htrans_d = cross_1k ? TR_NONSEQ : TR_SEQ;
            if (hburst_q != HB_INCR) begin
              cnt_d = cnt_q - 5'd1;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      last_q   <= IDXW'(NUM_REQ - 1);
      gidx_q   <= '0;
      gnt_q    <= '0;
      enable_q <= 1'b0;
      addr_q   <= '0;
      htrans_q <= TR_IDLE;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
      hburst_q <= '0;
      hselx_q  <= '0;
      cnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gidx_q   <= gidx_d;
      gnt_q    <= gnt_d;
      enable_q <= enable_d;
      addr_q   <= addr_d;
      htrans_q <= htrans_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
      hburst_q <= hburst_d;
      hselx_q  <= hselx_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign enable   = enable_q;
  assign addr     = addr_q;
  assign htrans   = htrans_q;
  assign hsize    = hsize_q;
  assign hwrite   = hwrite_q;
  assign hburst   = hburst_q;
  assign hselx    = hselx_q;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign beat_ack = ((state_q == S_BUSY) && hready) ? gnt_q : '0;
  assign w_data   = (state_q == S_BUSY) ? req_wdata[DATA_WIDTH*gidx_q +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_ahb_cmd_arbiter.sv
// Directed bench for ahb_cmd_arbiter: round robin, INCR/WRAP address sequences,
// 1 KB NONSEQ restart, stall hold, hresp abort, size reject and async reset.
module tb_ahb_cmd_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;

  logic                          HCLK;
  logic                          HRESET;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*32-1:0]         req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*3-1:0]          req_hsize;
  logic [NUM_REQ*3-1:0]          req_hburst;
  logic [NUM_REQ-1:0]            req_hwrite;
  logic [NUM_REQ*2-1:0]          req_hselx;
  logic                          hready;
  logic                          hresp;
  logic                          enable;
  logic [31:0]                   addr;
  logic [DATA_WIDTH-1:0]         w_data;
  logic [1:0]                    htrans;
  logic [2:0]                    hsize;
  logic                          hwrite;
  logic [2:0]                    hburst;
  logic [1:0]                    hselx;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            beat_ack;
  logic [NUM_REQ-1:0]            done;
  logic [NUM_REQ-1:0]            err;

  ahb_cmd_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_hsize(req_hsize), .req_hburst(req_hburst),
    .req_hwrite(req_hwrite), .req_hselx(req_hselx), .hready(hready), .hresp(hresp),
    .enable(enable), .addr(addr), .w_data(w_data), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hburst(hburst), .hselx(hselx), .gnt(gnt), .beat_ack(beat_ack),
    .done(done), .err(err)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_a[$];
  logic [1:0]  exp_t[$];
  logic [2:0]  exp_hsize;
  logic [2:0]  exp_hburst;
  logic        exp_hwrite;
  logic [1:0]  exp_hselx;
  logic [31:0] exp_wd;

  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int i, input logic [31:0] a, input logic [2:0] hs,
                         input logic [2:0] hb, input logic hw, input logic [1:0] hx,
                         input logic [31:0] wd);
    req_addr[32*i +: 32]           = a;
    req_hsize[3*i +: 3]            = hs;
    req_hburst[3*i +: 3]           = hb;
    req_hwrite[i]                  = hw;
    req_hselx[2*i +: 2]            = hx;
    req_wdata[DATA_WIDTH*i +: 32]  = wd;
    exp_hsize  = hs;
    exp_hburst = hb;
    exp_hwrite = hw;
    exp_hselx  = hx;
    exp_wd     = wd;
  endtask

  // Grants requester g, walks the expected address/HTRANS tables, then checks the done pulse.
  task automatic run_burst(input int g, input int drop_at);
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << g;
    step();
    chk("burst_hsize",  64'(hsize),  64'(exp_hsize));
    chk("burst_hburst", 64'(hburst), 64'(exp_hburst));
    chk("burst_hwrite", 64'(hwrite), 64'(exp_hwrite));
    chk("burst_hselx",  64'(hselx),  64'(exp_hselx));
    for (int b = 0; b < exp_a.size(); b++) begin
      chk("burst_addr",   64'(addr),     64'(exp_a[b]));
      chk("burst_htrans", 64'(htrans),   64'(exp_t[b]));
      chk("burst_gnt",    64'(gnt),      64'(oh));
      chk("burst_ack",    64'(beat_ack), 64'(oh));
      chk("burst_wdata",  64'(w_data),   64'(exp_wd));
      chk("burst_done",   64'(done),     64'd0);
      if (b == drop_at) req[g] = 1'b0;
      step();
    end
    chk("end_done",   64'(done),   64'(oh));
    chk("end_htrans", 64'(htrans), 64'd0);
    chk("end_enable", 64'(enable), 64'd0);
    chk("end_gnt",    64'(gnt),    64'd0);
    chk("end_err",    64'(err),    64'd0);
    chk("end_wdata",  64'(w_data), 64'd0);
    req[g] = 1'b0;
    step();
    chk("post_done", 64'(done), 64'd0);
    chk("post_gnt",  64'(gnt),  64'd0);
  endtask

  initial begin
    HRESET     = 1'b1;
    req        = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_hsize  = '0;
    req_hburst = '0;
    req_hwrite = '0;
    req_hselx  = '0;
    hready     = 1'b1;
    hresp      = 1'b0;
    exp_hsize  = '0;
    exp_hburst = '0;
    exp_hwrite = 1'b0;
    exp_hselx  = '0;
    exp_wd     = '0;

    // Reset values
    step();
    step();
    chk("rst_enable", 64'(enable), 64'd0);
    chk("rst_addr",   64'(addr),   64'd0);
    chk("rst_htrans", 64'(htrans), 64'd0);
    chk("rst_hsize",  64'(hsize),  64'd0);
    chk("rst_hburst", 64'(hburst), 64'd0);
    chk("rst_hwrite", 64'(hwrite), 64'd0);
    chk("rst_hselx",  64'(hselx),  64'd0);
    chk("rst_gnt",    64'(gnt),    64'd0);
    chk("rst_done",   64'(done),   64'd0);
    chk("rst_err",    64'(err),    64'd0);
    chk("rst_wdata",  64'(w_data), 64'd0);
    HRESET = 1'b0;
    step();
    chk("idle_gnt", 64'(gnt), 64'd0);

    // Round robin: all four hold SINGLE requests
    for (int i = 0; i < NUM_REQ; i++) set_cfg(i, 32'h10 * i, 3'd2, 3'd0, 1'b0, 2'd1, 32'h0);
    req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      logic [NUM_REQ-1:0] oh;
      oh = NUM_REQ'(1) << (n % 4);
      step();
      chk("rr_gnt",    64'(gnt),           64'(oh));
      chk("rr_htrans", 64'(htrans),        64'd2);
      chk("rr_onehot", 64'($onehot0(gnt)), 64'd1);
      if (n == 4) req = '0;
      step();
      chk("rr_gap_gnt",    64'(gnt),    64'd0);
      chk("rr_gap_htrans", 64'(htrans), 64'd0);
      chk("rr_done",       64'(done),   64'(oh));
    end
    step();
    chk("rr_quiet_gnt", 64'(gnt), 64'd0);

    // INCR4 at 0x100, req dropped after the first beat must not cut the burst short
    set_cfg(1, 32'h100, 3'd2, 3'd3, 1'b1, 2'd1, 32'hA5A5_0001);
    req[1] = 1'b1;
    exp_a = '{32'h100, 32'h104, 32'h108, 32'h10C};
    exp_t = '{2'd2, 2'd3, 2'd3, 2'd3};
    run_burst(1, 0);

    // WRAP4 at 0x38
    set_cfg(1, 32'h38, 3'd2, 3'd2, 1'b0, 2'd2, 32'h1234_5678);
    req[1] = 1'b1;
    exp_a = '{32'h38, 32'h3C, 32'h30, 32'h34};
    exp_t = '{2'd2, 2'd3, 2'd3, 2'd3};
    run_burst(1, 3);

    // WRAP8 halfword at 0x0E
    set_cfg(1, 32'h0E, 3'd1, 3'd4, 1'b1, 2'd3, 32'hCAFE_0002);
    req[1] = 1'b1;
    exp_a = '{32'h0E, 32'h00, 32'h02, 32'h04, 32'h06, 32'h08, 32'h0A, 32'h0C};
    exp_t = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    run_burst(1, 7);

    // Undefined-length INCR across the 1 KB boundary, ended by dropping req on beat 4
    set_cfg(2, 32'h3F8, 3'd2, 3'd1, 1'b1, 2'd1, 32'hBEEF_0003);
    req[2] = 1'b1;
    exp_a = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
    exp_t = '{2'd2, 2'd3, 2'd2, 2'd3};
    run_burst(2, 3);

    // INCR8 with a 3-cycle stall, then hresp abort on beat 5
    set_cfg(3, 32'h200, 3'd2, 3'd5, 1'b1, 2'd1, 32'h0);
    req[3] = 1'b1;
    step();
    chk("i8_b1_addr", 64'(addr), 64'h200);
    step();
    chk("i8_b2_addr",   64'(addr),   64'h204);
    chk("i8_b2_htrans", 64'(htrans), 64'd3);
    hready = 1'b0;
    #1;
    chk("stall_ack", 64'(beat_ack), 64'd0);
    for (int s = 0; s < 3; s++) begin
      step();
      chk("stall_addr",   64'(addr),   64'h204);
      chk("stall_htrans", 64'(htrans), 64'd3);
      chk("stall_enable", 64'(enable), 64'd1);
      chk("stall_gnt",    64'(gnt),    64'h8);
      chk("stall_done",   64'(done),   64'd0);
    end
    hready = 1'b1;
    step();
    chk("i8_b3_addr", 64'(addr), 64'h208);
    step();
    chk("i8_b4_addr", 64'(addr), 64'h20C);
    step();
    chk("i8_b5_addr", 64'(addr), 64'h210);
    hresp = 1'b1;
    step();
    chk("abort_err",    64'(err),    64'h8);
    chk("abort_done",   64'(done),   64'd0);
    chk("abort_htrans", 64'(htrans), 64'd0);
    chk("abort_enable", 64'(enable), 64'd0);
    chk("abort_gnt",    64'(gnt),    64'd0);
    hresp  = 1'b0;
    req[3] = 1'b0;
    step();
    chk("abort_err_clr",  64'(err),  64'd0);
    chk("abort_done_clr", 64'(done), 64'd0);

    // Oversize transfer is rejected
    set_cfg(0, 32'h40, 3'd3, 3'd0, 1'b1, 2'd1, 32'h0);
    req[0] = 1'b1;
    step();
    chk("rej_err",    64'(err),    64'h1);
    chk("rej_gnt",    64'(gnt),    64'd0);
    chk("rej_enable", 64'(enable), 64'd0);
    req[0] = 1'b0;
    step();
    chk("rej_err_clr", 64'(err), 64'd0);
    chk("rej_gnt_clr", 64'(gnt), 64'd0);

    // Async reset mid-burst, then requester 0 has first priority again
    set_cfg(2, 32'h0, 3'd2, 3'd3, 1'b1, 2'd1, 32'h5555_0004);
    req[2] = 1'b1;
    step();
    chk("rb_gnt", 64'(gnt), 64'h4);
    step();
    chk("rb_addr", 64'(addr), 64'h4);
    HRESET = 1'b1;
    #1;
    chk("arst_enable", 64'(enable),   64'd0);
    chk("arst_htrans", 64'(htrans),   64'd0);
    chk("arst_gnt",    64'(gnt),      64'd0);
    chk("arst_ack",    64'(beat_ack), 64'd0);
    chk("arst_addr",   64'(addr),     64'd0);
    chk("arst_wdata",  64'(w_data),   64'd0);
    chk("arst_done",   64'(done),     64'd0);
    chk("arst_err",    64'(err),      64'd0);
    set_cfg(0, 32'h80, 3'd2, 3'd0, 1'b0, 2'd1, 32'h0);
    req = 4'b0101;
    step();
    chk("arst_hold_gnt", 64'(gnt), 64'd0);
    HRESET = 1'b0;
    step();
    chk("post_rst_gnt",    64'(gnt),    64'h1);
    chk("post_rst_htrans", 64'(htrans), 64'd2);
    chk("post_rst_addr",   64'(addr),   64'h80);
    req = '0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
